cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single result broadcast bus (CDB) between the two execution producers: ALU and the store/load buffer (SLB).
- The registered bus output feeds the reorder buffer, the reservation station and the SLB for wake-up and completion marking.
- Arbitration is round-robin, with a valid/ready handshake on each producer and backpressure from the bus consumer.
- A flush input discards in-flight results on a branch exception.

Parameters:
DataWidth, 32, width of the result data and of the PC/tag fields.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
flush  input  1  exception flush from the reorder buffer; synchronous.
alu_valid  input  1  ALU result available.
alu_pc  input  DataWidth  PC (tag) of the ALU result.
alu_data  input  DataWidth  ALU result value.
alu_jpc  input  DataWidth  ALU next/jump PC.
alu_ready  output  1  ALU result accepted this cycle (combinational).
slb_valid  input  1  SLB result available.
slb_pc  input  DataWidth  PC (tag) of the SLB result.
slb_data  input  DataWidth  SLB load data (0 for stores).
slb_ready  output  1  SLB result accepted this cycle (combinational).
bus_ready  input  1  consumer can take the bus word this cycle.
bus_valid  output  1  bus word valid.
bus_pc  output  DataWidth  broadcast tag.
bus_data  output  DataWidth  broadcast data.
bus_jpc  output  DataWidth  broadcast next PC.
bus_src  output  1  0 = ALU, 1 = SLB.

Behaviour:
- All state updates on posedge clk. Priority order: rst, then flush, then normal operation.
- Reset:
  - bus_valid, bus_pc, bus_data, bus_jpc and bus_src all go to 0.
  - Internal last_grant goes to 1 (SLB), so the ALU wins the first conflict.
  - alu_ready and slb_ready are 0 while rst = 1.
- load_en = !bus_valid || bus_ready. The output register can accept a new word only when load_en = 1.
- Grant is combinational and applies only when load_en && !flush && !rst:
  - Only alu_valid: grant ALU.
  - Only slb_valid: grant SLB.
  - Both valid: grant the source != last_grant.
  - Neither valid: no grant.
- alu_ready = grant_alu and slb_ready = grant_slb. At most one of them is 1 per cycle.
- Producers must not make valid depend on ready. A producer holds valid and its fields stable until ready = 1.
- On a grant, the next edge does the following:
  - bus_valid <= 1.
  - bus_pc and bus_data are loaded from the granted source; bus_src is set to the granted source.
  - bus_jpc <= alu_jpc for an ALU grant, or slb_pc + 4 for an SLB grant (modulo 2^DataWidth).
  - last_grant <= granted source.
- load_en = 1 with no grant: bus_valid <= 0 and the data fields hold their last values.
- bus_valid = 1 and bus_ready = 0: every bus_* output holds, both readies are 0, and last_grant holds.
- Latency and throughput:
  - A result accepted at edge N is visible on the bus from after edge N until the edge on which bus_ready = 1.
  - Sustained throughput is 1 word/cycle when bus_ready is held at 1.
- Fairness: with both producers continuously valid and bus_ready = 1, grants strictly alternate. Neither producer waits more than 1 accepted word.
- Flush:
  - bus_valid <= 0, and both readies are 0 in the flush cycle, so nothing is accepted.
  - last_grant <= 1, and the data fields hold.
  - Producers are expected to drop their own results on flush.
- Flush and bus_ready = 1 in the same cycle: the flush wins. The held word is dropped, not delivered.
- Reset asserted mid-transfer: the bus word is discarded and the behaviour matches reset.

Optional Feature:
- Macro: CDB_PERF_CNT_EN.
- When defined, the block adds three 32-bit output counters:
  - perf_alu_grants: increments on each ALU grant.
  - perf_slb_grants: increments on each SLB grant.
  - perf_conflicts: increments on each cycle with alu_valid && slb_valid && load_en && !flush.
- Counter rules:
  - All three reset to 0 on rst only; flush does not clear them.
  - They wrap at 2^32.
- When the macro is undefined, these ports and their logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset: rst = 1 for 2 cycles with alu_valid = slb_valid = 1 -> both readies 0 and bus_valid = 0. On the first post-reset conflict, bus_src = 0.
- ALU only: alu_valid = 1, pc = 0x100, data = 0x55, jpc = 0x200, bus_ready = 1 -> alu_ready = 1 for one cycle. Next cycle bus_valid = 1, pc = 0x100, data = 0x55, jpc = 0x200, src = 0.
- SLB only: slb_pc = 0x0FFC, data = 0xDEADBEEF -> bus_jpc = 0x1000, src = 1. With slb_pc = 0xFFFFFFFC -> bus_jpc = 0x0.
- Contention: both valid for 6 cycles, bus_ready = 1 -> grants go ALU, SLB, ALU, SLB, ALU, SLB, with no cycle granting both.
- Backpressure: a word is on the bus and bus_ready = 0 for 3 cycles with both producers valid -> the bus holds its value, readies stay 0 and last_grant is unchanged. When bus_ready rises, the next granted source is the one after the held word's source.
- Flush: a word is on the bus with bus_ready = 1 and flush = 1 in the same cycle -> bus_valid = 0 next cycle and no ready asserted. The first conflict after the flush grants the ALU.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered result broadcast bus between the ALU and the SLB.
// Optional performance counters are enabled by defining CDB_PERF_CNT_EN.
module cdb_arbiter #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alu_valid,
  input  logic [DataWidth-1:0] alu_pc,
  input  logic [DataWidth-1:0] alu_data,
  input  logic [DataWidth-1:0] alu_jpc,
  output logic                 alu_ready,
  input  logic                 slb_valid,
  input  logic [DataWidth-1:0] slb_pc,
  input  logic [DataWidth-1:0] slb_data,
  output logic                 slb_ready,
  input  logic                 bus_ready,
  output logic                 bus_valid,
  output logic [DataWidth-1:0] bus_pc,
  output logic [DataWidth-1:0] bus_data,
  output logic [DataWidth-1:0] bus_jpc,
  output logic                 bus_src
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_alu_grants,
  output logic [31:0]          perf_slb_grants,
  output logic [31:0]          perf_conflicts
`endif
);

  logic                 bus_valid_q, bus_valid_d;
  logic [DataWidth-1:0] bus_pc_q, bus_pc_d;
  logic [DataWidth-1:0] bus_data_q, bus_data_d;
  logic [DataWidth-1:0] bus_jpc_q, bus_jpc_d;
  logic                 bus_src_q, bus_src_d;
  logic                 last_grant_q, last_grant_d;
  logic                 load_en, grant_alu, grant_slb;

  assign load_en = !bus_valid_q || bus_ready;

  // last_grant_q = 1 means the SLB won last, so the ALU wins the next conflict.
  always_comb begin
    grant_alu = 1'b0;
    grant_slb = 1'b0;
    if (load_en && !flush && !rst) begin
      if (alu_valid && slb_valid) begin
        grant_alu = last_grant_q;
        grant_slb = !last_grant_q;
      end else begin
        grant_alu = alu_valid;
        grant_slb = slb_valid;
      end
    end
  end

  always_comb begin
    bus_valid_d  = bus_valid_q;
    bus_pc_d     = bus_pc_q;
    bus_data_d   = bus_data_q;
    bus_jpc_d    = bus_jpc_q;
    bus_src_d    = bus_src_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      bus_valid_d  = 1'b0;
      last_grant_d = 1'b1;
    end else if (load_en) begin
      bus_valid_d = grant_alu || grant_slb;
      if (grant_alu) begin
        bus_pc_d     = alu_pc;
        bus_data_d   = alu_data;
        bus_jpc_d    = alu_jpc;
        bus_src_d    = 1'b0;
        last_grant_d = 1'b0;
      end else if (grant_slb) begin
        bus_pc_d     = slb_pc;
        bus_data_d   = slb_data;
        bus_jpc_d    = slb_pc + DataWidth'(4);
        bus_src_d    = 1'b1;
        last_grant_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_valid_q  <= 1'b0;
      bus_pc_q     <= '0;
      bus_data_q   <= '0;
      bus_jpc_q    <= '0;
      bus_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      bus_valid_q  <= bus_valid_d;
      bus_pc_q     <= bus_pc_d;
      bus_data_q   <= bus_data_d;
      bus_jpc_q    <= bus_jpc_d;
      bus_src_q    <= bus_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign alu_ready = grant_alu;
  assign slb_ready = grant_slb;
  assign bus_valid = bus_valid_q;
  assign bus_pc    = bus_pc_q;
  assign bus_data  = bus_data_q;
  assign bus_jpc   = bus_jpc_q;
  assign bus_src   = bus_src_q;

`ifdef CDB_PERF_CNT_EN
  logic [31:0] perf_alu_q, perf_slb_q, perf_conf_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_alu_q  <= '0;
      perf_slb_q  <= '0;
      perf_conf_q <= '0;
    end else begin
      if (grant_alu) perf_alu_q <= perf_alu_q + 32'd1;
      if (grant_slb) perf_slb_q <= perf_slb_q + 32'd1;
      if (alu_valid && slb_valid && load_en && !flush) perf_conf_q <= perf_conf_q + 32'd1;
    end
  end

  assign perf_alu_grants = perf_alu_q;
  assign perf_slb_grants = perf_slb_q;
  assign perf_conflicts  = perf_conf_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table followed by randomized traffic vs a reference model.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush, alu_valid, slb_valid, bus_ready;
  logic [31:0] alu_pc, alu_data, alu_jpc, slb_pc, slb_data;
  logic        alu_ready, slb_ready, bus_valid, bus_src;
  logic [31:0] bus_pc, bus_data, bus_jpc;
`ifdef CDB_PERF_CNT_EN
  logic [31:0] perf_alu_grants, perf_slb_grants, perf_conflicts;
`endif

  always #5 clk = ~clk;

  cdb_arbiter #(.DataWidth(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .alu_valid (alu_valid),
    .alu_pc    (alu_pc),
    .alu_data  (alu_data),
    .alu_jpc   (alu_jpc),
    .alu_ready (alu_ready),
    .slb_valid (slb_valid),
    .slb_pc    (slb_pc),
    .slb_data  (slb_data),
    .slb_ready (slb_ready),
    .bus_ready (bus_ready),
    .bus_valid (bus_valid),
    .bus_pc    (bus_pc),
    .bus_data  (bus_data),
    .bus_jpc   (bus_jpc),
    .bus_src   (bus_src)
`ifdef CDB_PERF_CNT_EN
    ,
    .perf_alu_grants (perf_alu_grants),
    .perf_slb_grants (perf_slb_grants),
    .perf_conflicts  (perf_conflicts)
`endif
  );

  // Directed row: slb_sel picks SLB inputs (0: 0xFFC/0xDEADBEEF, 1: 0xFFFFFFFC/0x12345678);
  // word picks the expected bus contents (0 zero, 1 ALU word, 2 SLB word, 3 wrapped SLB word).
  typedef struct {
    logic r, f, av, sv, br;
    int   slb_sel;
    logic ear, esr, ebv;
    int   word;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the word currently on the bus and who won the last grant.
  logic        m_valid, m_src;
  logic [31:0] m_pc, m_data, m_jpc;
  int          m_last_winner;  // 0 ALU, 1 SLB
  logic [31:0] m_pa, m_ps, m_pconf;

  function automatic vec_t mk(logic r, f, av, sv, br, int slb_sel, logic ear, esr, ebv, int word);
    vec_t v;
    v.r = r; v.f = f; v.av = av; v.sv = sv; v.br = br; v.slb_sel = slb_sel;
    v.ear = ear; v.esr = esr; v.ebv = ebv; v.word = word;
    return v;
  endfunction

  task automatic word_of(input int w, output logic [31:0] pc, data, jpc, output logic src);
    case (w)
      1:       begin pc = 32'h100;      data = 32'h55;       jpc = 32'h200;  src = 1'b0; end
      2:       begin pc = 32'hFFC;      data = 32'hDEADBEEF; jpc = 32'h1000; src = 1'b1; end
      3:       begin pc = 32'hFFFFFFFC; data = 32'h12345678; jpc = 32'h0;    src = 1'b1; end
      default: begin pc = 32'h0;        data = 32'h0;        jpc = 32'h0;    src = 1'b0; end
    endcase
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act, exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_src = 1'b0; m_pc = '0; m_data = '0; m_jpc = '0;
    m_last_winner = 1; m_pa = '0; m_ps = '0; m_pconf = '0;
  endtask

  task automatic model_ready(output logic ear, esr);
    ear = 1'b0; esr = 1'b0;
    if (!rst && !flush && (!m_valid || bus_ready)) begin
      if (alu_valid && slb_valid) begin
        if (m_last_winner == 1) ear = 1'b1; else esr = 1'b1;
      end else begin
        ear = alu_valid; esr = slb_valid;
      end
    end
  endtask

  task automatic model_edge(input logic ear, esr);
    logic take;
    take = !m_valid || bus_ready;
    if (rst) begin
      model_reset();
    end else begin
      if (ear) m_pa++;
      if (esr) m_ps++;
      if (alu_valid && slb_valid && take && !flush) m_pconf++;
      if (flush) begin
        m_valid = 1'b0; m_last_winner = 1;
      end else if (take) begin
        m_valid = ear || esr;
        if (ear) begin
          m_pc = alu_pc; m_data = alu_data; m_jpc = alu_jpc; m_src = 1'b0; m_last_winner = 0;
        end else if (esr) begin
          m_pc = slb_pc; m_data = slb_data; m_jpc = slb_pc + 32'd4; m_src = 1'b1;
          m_last_winner = 1;
        end
      end
    end
  endtask

  // One clock: inputs are already driven; readies checked before the edge, bus after it.
  task automatic step(input bit use_row, input vec_t v, input int cyc,
                      output logic got_ar, output logic got_sr);
    logic ear, esr, xsrc;
    logic [31:0] xpc, xdata, xjpc;
    #1;
    model_ready(ear, esr);
    got_ar = alu_ready;
    got_sr = slb_ready;
    chk("alu_ready", cyc, {31'b0, alu_ready}, {31'b0, use_row ? v.ear : ear});
    chk("slb_ready", cyc, {31'b0, slb_ready}, {31'b0, use_row ? v.esr : esr});
    @(posedge clk);
    model_edge(ear, esr);
    #1;
    if (use_row) begin
      word_of(v.word, xpc, xdata, xjpc, xsrc);
      chk("bus_valid", cyc, {31'b0, bus_valid}, {31'b0, v.ebv});
    end else begin
      xpc = m_pc; xdata = m_data; xjpc = m_jpc; xsrc = m_src;
      chk("bus_valid", cyc, {31'b0, bus_valid}, {31'b0, m_valid});
    end
    chk("bus_pc", cyc, bus_pc, xpc);
    chk("bus_data", cyc, bus_data, xdata);
    chk("bus_jpc", cyc, bus_jpc, xjpc);
    chk("bus_src", cyc, {31'b0, bus_src}, {31'b0, xsrc});
`ifdef CDB_PERF_CNT_EN
    chk("perf_alu_grants", cyc, perf_alu_grants, m_pa);
    chk("perf_slb_grants", cyc, perf_slb_grants, m_ps);
    chk("perf_conflicts", cyc, perf_conflicts, m_pconf);
`endif
    @(negedge clk);
  endtask

  vec_t vecs[$];

  initial begin
    logic ar, sr, pend_a, pend_s;
    vec_t dummy;
    dummy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    rst = 1'b1; flush = 1'b0; alu_valid = 1'b0; slb_valid = 1'b0; bus_ready = 1'b0;
    alu_pc = '0; alu_data = '0; alu_jpc = '0; slb_pc = '0; slb_data = '0;

    //          r  f  av sv br sel ear esr ebv word
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 0));  // reset with both valid
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 1, 1));  // contention: A S A S A S
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 1, 2));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 1, 2));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2));  // idle: valid drops, fields hold
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 1, 1));  // ALU only
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 1));  // backpressure x3
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 1, 2));  // release: SLB follows held ALU word
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 1, 1, 3));  // SLB only, jpc wraps to 0
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 1));  // flush beats bus_ready
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 1, 1));  // ALU wins after flush
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 1, 2));
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 0));  // reset mid-transfer
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 1, 1));

    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].r; flush = vecs[i].f; bus_ready = vecs[i].br;
      alu_valid = vecs[i].av; alu_pc = 32'h100; alu_data = 32'h55; alu_jpc = 32'h200;
      slb_valid = vecs[i].sv;
      slb_pc    = (vecs[i].slb_sel == 1) ? 32'hFFFFFFFC : 32'hFFC;
      slb_data  = (vecs[i].slb_sel == 1) ? 32'h12345678 : 32'hDEADBEEF;
      step(1'b1, vecs[i], i, ar, sr);
      if (ar && sr) chk("one_grant", i, 32'd1, 32'd0);
    end

    // Randomized traffic: producers hold valid and fields until accepted, drop on flush/reset.
    pend_a = 1'b0; pend_s = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 24) == 0);
      bus_ready = ($urandom_range(0, 3) != 0);
      if (!pend_a && $urandom_range(0, 2) != 0) begin
        pend_a = 1'b1; alu_pc = $urandom; alu_data = $urandom; alu_jpc = $urandom;
      end
      if (!pend_s && $urandom_range(0, 2) != 0) begin
        pend_s = 1'b1; slb_data = $urandom;
        slb_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      end
      alu_valid = pend_a; slb_valid = pend_s;
      step(1'b0, dummy, 1000 + c, ar, sr);
      if (ar && sr) chk("one_grant", 1000 + c, 32'd1, 32'd0);
      if (ar) pend_a = 1'b0;
      if (sr) pend_s = 1'b0;
      if (rst || flush) begin pend_a = 1'b0; pend_s = 1'b0; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
